// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder. The master drives the operands and start;
// the slave (the adder) returns status and the registered result.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice and a carry flop, LSB first, one bit per cycle.
// IDLE -> RUN (WIDTH cycles) -> DONE (one cycle), DONE may chain straight into a new RUN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 10
) (
    input logic              clk,
    input logic              reset,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s, fa_co;

    // Full-adder slice on the current LSBs and the carry flop.
    always_comb begin
        fa_s  = a_q[0] ^ b_q[0] ^ c_q;
        fa_co = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    end

    // Next-state and datapath control; results only move on the final RUN edge.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.cin;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                r_d   = {fa_s, r_q[WIDTH-1:1]};
                c_d   = fa_co;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    sum_d   = {fa_s, r_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    // c_q here is still the carry into the MSB.
                    ovf_d   = c_q ^ fa_co;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status decodes straight from the state register.
    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StDone);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovf  = ovf_q;
    end
endmodule
